squaring_scheduler: RTL and testbench
=====================================

Name: squaring_scheduler

Overview:
- Time-shares one modular-squaring core among SLOTS independent timelock puzzles.
- Each slot holds a redundant-form state word (sum+carry, WIDTH bits) and a remaining-iteration count.
- Round-robin arbiter grants busy slots one squaring at a time, writes results back and flags completion.
- Sits between the host-side command controller and the squaring datapath.

Parameters:
- SLOTS, 4, number of puzzle slots (power of two, ≥2)
- SLOT_W, 2, log2(SLOTS)
- WIDTH, 368, state word width (184-bit sum + 184-bit carry)
- CNT_W, 32, iteration counter width
- BURST, 4, max consecutive squarings per grant (used only with SCHED_BURST_EN)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- host_start  in  1  load-and-start strobe for host_slot
- host_slot  in  SLOT_W  target slot for start/read
- host_data  in  WIDTH  initial state word
- host_count  in  CNT_W  number of squarings to perform
- host_err  out  1  one-cycle pulse: start rejected
- host_rd_data  out  WIDTH  state word of host_slot (combinational read)
- done  out  SLOTS  per-slot sticky completion flags
- busy  out  SLOTS  per-slot active flags
- sq_start  out  1  one-cycle issue pulse to core
- sq_x  out  WIDTH  operand, held stable from sq_start until sq_done
- sq_ready  in  1  core idle, may accept sq_start
- sq_done  in  1  one-cycle result-valid pulse
- sq_y  in  WIDTH  result, valid with sq_done

Behaviour:
- Reset: all state words 0, counts 0, busy=0, done=0, sq_start=0, host_err=0, rr pointer=SLOTS-1, FSM=IDLE.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: if any busy bit is set, grant the first busy slot strictly after the rr pointer (wrapping). Latch the slot into gnt, drive sq_x from its word, go to ISSUE. No other state is entered from IDLE.
- ISSUE: wait for sq_ready=1. In that cycle assert sq_start for exactly one cycle, then go to WAIT.
- WAIT: on sq_done, write sq_y into the gnt slot's word and decrement its count.
  - If the new count is 0: clear busy[gnt], set done[gnt].
  - Set rr pointer=gnt. Return to IDLE.
  - Per-slot throughput: one squaring every ≥3 cycles plus core latency.
- sq_done outside WAIT is ignored (stale completion after reset).
- Host start on slot s:
  - Rejected if busy[s] and s==gnt and FSM≠IDLE (operation in flight): host_err pulses, slot unchanged.
  - Otherwise: word[s]=host_data, count[s]=host_count, done[s]=0, busy[s]=(host_count≠0).
  - host_count=0: done[s]=1 the next cycle, word unchanged from host_data.
  - Start on a busy but not-granted slot restarts it.
- Simultaneous host_start and write-back on different slots: both take effect. The same slot cannot occur (rejected).
- Count arithmetic: unsigned, decrement only while count>0; never wraps.
- Reset mid-operation: all state cleared immediately; the core is not aborted and its later sq_done is ignored.

Optional Feature:
- Macro SCHED_BURST_EN.
- Defined: on write-back with count still >0, the same slot is re-issued directly (WAIT→ISSUE) until BURST squarings have been done in this grant. It then rotates through IDLE. A burst counter resets on each new grant.
- Not defined: strict one-squaring-per-grant rotation as above; BURST unused.

Test Plan:
- Single slot: start slot 0, x=2, count=1000, model core y=x² mod N. Required: done[0] set, busy[0]=0, host_rd_data equals the reference value after 1000 squarings, exactly 1000 sq_start pulses.
- Fairness: start slots 0–3 with count=3 each in the same ~4 cycles. Required (burst off): grant order 0,1,2,3,0,1,2,3,0,1,2,3; all done together at the end. Burst on with BURST=4: order 0,0,0,1,1,1,…
- Zero count: start slot 2 with count=0. Required: done[2]=1 next cycle, no sq_start issued.
- Rejection: while slot 1 is in WAIT, start slot 1. Required: host_err one-cycle pulse; slot 1 result and count unaffected. Start slot 3 (idle) in the same phase is accepted.
- Slow core: hold sq_ready=0 for 20 cycles in ISSUE. Required: sq_start held off until sq_ready=1; sq_x stable throughout.
- Reset mid-WAIT: assert rst, then deliver a stale sq_done. Required: all words 0, busy/done 0, no write-back, FSM IDLE.

Source files
------------

// File: rtl/squaring_scheduler.sv
// squaring_scheduler: round-robin time-sharing of one modular-squaring core.
// Optional SCHED_BURST_EN: a grant may issue up to BURST back-to-back squarings.
module squaring_scheduler #(
   parameter int SLOTS  = 4,
   parameter int SLOT_W = 2,
   parameter int WIDTH  = 368,
   parameter int CNT_W  = 32,
   parameter int BURST  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              host_start,
   input  logic [SLOT_W-1:0] host_slot,
   input  logic [WIDTH-1:0]  host_data,
   input  logic [CNT_W-1:0]  host_count,
   output logic              host_err,
   output logic [WIDTH-1:0]  host_rd_data,
   output logic [SLOTS-1:0]  done,
   output logic [SLOTS-1:0]  busy,
   output logic              sq_start,
   output logic [WIDTH-1:0]  sq_x,
   input  logic              sq_ready,
   input  logic              sq_done,
   input  logic [WIDTH-1:0]  sq_y
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t            state, state_nx;
   logic [WIDTH-1:0]  word [SLOTS];
   logic [CNT_W-1:0]  cnt  [SLOTS];
   logic [SLOT_W-1:0] rr, gnt, pick, idx;
   logic              pick_vld;
   logic              wb, last, again;
   logic              accept, reject;
   logic [CNT_W-1:0]  cnt_nx;

   // first busy slot strictly after rr, wrapping
   always_comb begin
      pick     = rr;
      pick_vld = 1'b0;
      idx      = rr;
      for (int i = 1; i <= SLOTS; i++) begin
         idx = rr + SLOT_W'(i);
         if (!pick_vld && busy[idx]) begin
            pick     = idx;
            pick_vld = 1'b1;
         end
      end
   end

   assign wb     = (state == WAIT) && sq_done;
   assign cnt_nx = (cnt[gnt] != '0) ? cnt[gnt] - CNT_W'(1) : cnt[gnt];
   assign last   = (cnt_nx == '0);
   assign reject = host_start && busy[host_slot] &&
                   (host_slot == gnt) && (state != IDLE);
   assign accept = host_start && !reject;

`ifdef SCHED_BURST_EN
   localparam int BC_W = $clog2(BURST + 1);
   logic [BC_W-1:0] bcnt;

   assign again = !last && ((int'(bcnt) + 1) < BURST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         bcnt <= '0;
      else if (state == IDLE)
         bcnt <= '0;
      else if (wb)
         bcnt <= bcnt + BC_W'(1);
   end
`else
   assign again = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (pick_vld) state_nx = ISSUE;
         ISSUE:   if (sq_ready) state_nx = WAIT;
         WAIT:    if (sq_done)  state_nx = again ? ISSUE : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      sq_start     = (state == ISSUE) && sq_ready;
      sq_x         = word[gnt];
      host_rd_data = word[host_slot];
   end

   // write-back and host start never target the same slot
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < SLOTS; s++) begin
            word[s] <= '0;
            cnt[s]  <= '0;
         end
         busy     <= '0;
         done     <= '0;
         rr       <= SLOT_W'(SLOTS - 1);
         gnt      <= '0;
         host_err <= 1'b0;
      end else begin
         host_err <= reject;
         if (state == IDLE && pick_vld)
            gnt <= pick;
         if (wb) begin
            word[gnt] <= sq_y;
            cnt[gnt]  <= cnt_nx;
            rr        <= gnt;
            if (last) begin
               busy[gnt] <= 1'b0;
               done[gnt] <= 1'b1;
            end
         end
         if (accept) begin
            word[host_slot] <= host_data;
            cnt[host_slot]  <= host_count;
            busy[host_slot] <= (host_count != '0);
            done[host_slot] <= (host_count == '0);
         end
      end
   end

endmodule

// File: tb/tb_squaring_scheduler.sv
// tb_squaring_scheduler: random-data bench with a behavioural squaring core
// and a slot-level reference model (iterated x^2 mod N per slot).
`timescale 1ns/1ps
module tb_squaring_scheduler;

   localparam int SLOTS  = 4;
   localparam int SLOT_W = 2;
   localparam int WIDTH  = 368;
   localparam int CNT_W  = 32;
   localparam int BURST  = 4;
   localparam logic [63:0] MODN = 64'hFFFF_FFFF_FFFF_FFC5;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              host_start = 1'b0;
   logic [SLOT_W-1:0] host_slot = '0;
   logic [WIDTH-1:0]  host_data = '0;
   logic [CNT_W-1:0]  host_count = '0;
   logic              host_err;
   logic [WIDTH-1:0]  host_rd_data;
   logic [SLOTS-1:0]  done, busy;
   logic              sq_start;
   logic [WIDTH-1:0]  sq_x;
   logic              sq_ready;
   logic              sq_done;
   logic [WIDTH-1:0]  sq_y;

   squaring_scheduler #(
      .SLOTS(SLOTS), .SLOT_W(SLOT_W), .WIDTH(WIDTH),
      .CNT_W(CNT_W), .BURST(BURST)
   ) dut (
      .clk(clk), .rst(rst),
      .host_start(host_start), .host_slot(host_slot),
      .host_data(host_data), .host_count(host_count),
      .host_err(host_err), .host_rd_data(host_rd_data),
      .done(done), .busy(busy),
      .sq_start(sq_start), .sq_x(sq_x), .sq_ready(sq_ready),
      .sq_done(sq_done), .sq_y(sq_y)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag,
                        input logic [WIDTH-1:0] got,
                        input logic [WIDTH-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] sqmod(input logic [WIDTH-1:0] x);
      logic [127:0] p;
      p = {64'b0, x[63:0]} * {64'b0, x[63:0]};
      return WIDTH'(p % {64'b0, MODN});
   endfunction

   function automatic logic [WIDTH-1:0] iter(input logic [WIDTH-1:0] x,
                                             input int n);
      logic [WIDTH-1:0] y;
      y = x;
      for (int i = 0; i < n; i++) y = sqmod(y);
      return y;
   endfunction

   function automatic logic [WIDTH-1:0] rnd_word();
      logic [WIDTH-1:0] w;
      w = '0;
      for (int i = 0; i < 12; i++) w = {w[WIDTH-33:0], 32'($urandom)};
      w[63] = 1'b0;
      return w;
   endfunction

   // reference model: what each slot's word is, and squarings still owed
   logic [WIDTH-1:0] cur [SLOTS];
   int               mcnt [SLOTS];
   int               q_order [$];
   int               n_issue = 0;
   int               epoch = 0;
   bit               ready_en = 1'b1;
   int               lat_fix = 0;
   bit               issued = 1'b0;
   int               lat_left = 0;
   logic [WIDTH-1:0] cx;
   int               c_slot = -1;
   int               c_epoch = 0;

   initial begin
      for (int s = 0; s < SLOTS; s++) begin
         cur[s]  = '0;
         mcnt[s] = 0;
      end
   end

   // issue monitor: identify the granted slot by its operand
   always @(negedge clk) begin
      int s;
      if (sq_start) begin
         s = -1;
         for (int i = 0; i < SLOTS; i++)
            if (s < 0 && mcnt[i] > 0 && cur[i] == sq_x) s = i;
         n_issue++;
         q_order.push_back(s);
         issued  = 1'b1;
         cx      = sq_x;
         c_slot  = s;
         c_epoch = epoch;
      end
   end

   // behavioural squaring core with random or fixed latency
   initial begin
      sq_ready = 1'b0;
      sq_done  = 1'b0;
      sq_y     = '0;
      forever begin
         @(posedge clk);
         #1;
         sq_done = 1'b0;
         if (issued) begin
            issued   = 1'b0;
            sq_ready = 1'b0;
            lat_left = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 4));
         end else if (lat_left > 0) begin
            lat_left--;
            if (lat_left == 0) begin
               sq_done = 1'b1;
               sq_y    = sqmod(cx);
               if (c_epoch == epoch && c_slot >= 0) begin
                  cur[c_slot] = sq_y;
                  mcnt[c_slot]--;
               end
            end
         end else begin
            sq_ready = ready_en;
         end
      end
   end

   task automatic host_op(input int s, input logic [WIDTH-1:0] d,
                          input int c, input bit acc);
      @(posedge clk);
      #1;
      host_start = 1'b1;
      host_slot  = SLOT_W'(s);
      host_data  = d;
      host_count = CNT_W'(c);
      if (acc) begin
         cur[s]  = d;
         mcnt[s] = c;
      end
      @(posedge clk);
      #1;
      host_start = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      epoch++;
      for (int s = 0; s < SLOTS; s++) begin
         cur[s]  = '0;
         mcnt[s] = 0;
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic wait_done(input logic [SLOTS-1:0] mask,
                            input int budget, input string tag);
      int k;
      k = 0;
      while ((done & mask) != mask && k < budget) begin
         @(negedge clk);
         k++;
      end
      check(tag, WIDTH'(done & mask), WIDTH'(mask));
   endtask

   task automatic wait_issue(input int n0, input int budget,
                             input string tag);
      int k;
      k = 0;
      while (n_issue == n0 && k < budget) begin
         @(negedge clk);
         k++;
      end
      check(tag, WIDTH'(n_issue > n0), WIDTH'(1));
   endtask

   task automatic rd_check(input int s, input logic [WIDTH-1:0] exp,
                           input string tag);
      host_slot = SLOT_W'(s);
      @(negedge clk);
      check(tag, host_rd_data, exp);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [WIDTH-1:0] d [SLOTS];
      logic [WIDTH-1:0] dx;
      int               cnts [SLOTS];
      int               n0, tot;
      int               exp_order [$];

      // reset state
      repeat (2) @(negedge clk);
      check("rst_busy", WIDTH'(busy), '0);
      check("rst_done", WIDTH'(done), '0);
      check("rst_start", WIDTH'(sq_start), '0);
      check("rst_err", WIDTH'(host_err), '0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int s = 0; s < SLOTS; s++) rd_check(s, '0, "rst_word");

      // single slot, long run
      n0 = n_issue;
      host_op(0, WIDTH'(2), 1000, 1'b1);
      wait_done(4'b0001, 20000, "single_done");
      check("single_busy", WIDTH'(busy[0]), '0);
      rd_check(0, iter(WIDTH'(2), 1000), "single_word");
      check("single_issues", WIDTH'(n_issue - n0), WIDTH'(1000));

      // zero count
      n0 = n_issue;
      dx = rnd_word();
      host_op(2, dx, 0, 1'b1);
      @(negedge clk);
      check("zero_done", WIDTH'(done[2]), WIDTH'(1));
      check("zero_busy", WIDTH'(busy[2]), '0);
      repeat (5) @(negedge clk);
      check("zero_issues", WIDTH'(n_issue - n0), '0);
      rd_check(2, dx, "zero_word");

      // slow core: ready held low while slot 1 sits in ISSUE
      ready_en = 1'b0;
      @(posedge clk);
      #1;
      n0 = n_issue;
      dx = rnd_word();
      host_op(1, dx, 2, 1'b1);
      @(negedge clk);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("slow_hold", WIDTH'(sq_start), '0);
         check("slow_x", sq_x, dx);
      end
      ready_en = 1'b1;
      wait_done(4'b0010, 200, "slow_done");
      rd_check(1, iter(dx, 2), "slow_word");
      check("slow_issues", WIDTH'(n_issue - n0), WIDTH'(2));

      // rejection of slot 1 in flight, slot 3 accepted meanwhile
      lat_fix = 12;
      n0 = n_issue;
      d[1] = rnd_word();
      d[3] = rnd_word();
      host_op(1, d[1], 4, 1'b1);
      wait_issue(n0, 100, "rej_issue");
      host_op(1, rnd_word(), 7, 1'b0);
      @(negedge clk);
      check("rej_err", WIDTH'(host_err), WIDTH'(1));
      host_op(3, d[3], 2, 1'b1);
      @(negedge clk);
      check("acc_err", WIDTH'(host_err), '0);
      lat_fix = 0;
      wait_done(4'b1010, 500, "rej_done");
      rd_check(1, iter(d[1], 4), "rej_word1");
      rd_check(3, iter(d[3], 2), "acc_word3");

      // fairness from a fresh round-robin pointer
      do_reset();
      ready_en = 1'b0;
      q_order.delete();
      for (int s = 0; s < SLOTS; s++) begin
         d[s] = rnd_word();
         host_op(s, d[s], 3, 1'b1);
      end
      ready_en = 1'b1;
      wait_done(4'b1111, 2000, "fair_done");
`ifdef SCHED_BURST_EN
      for (int s = 0; s < SLOTS; s++)
         for (int r = 0; r < ((BURST < 3) ? BURST : 3); r++)
            exp_order.push_back(s);
      for (int s = 0; s < SLOTS; s++)
         for (int r = BURST; r < 3; r++)
            exp_order.push_back(s);
`else
      for (int r = 0; r < 3; r++)
         for (int s = 0; s < SLOTS; s++)
            exp_order.push_back(s);
`endif
      check("fair_len", WIDTH'(q_order.size()), WIDTH'(exp_order.size()));
      for (int i = 0; i < exp_order.size() && i < q_order.size(); i++)
         check($sformatf("fair_order%0d", i),
               WIDTH'(q_order[i]), WIDTH'(exp_order[i]));
      for (int s = 0; s < SLOTS; s++)
         rd_check(s, iter(d[s], 3), "fair_word");

      // random counts and data across all slots
      for (int r = 0; r < 3; r++) begin
         n0  = n_issue;
         tot = 0;
         for (int s = 0; s < SLOTS; s++) begin
            d[s]    = rnd_word();
            cnts[s] = int'($urandom_range(1, 10));
            tot    += cnts[s];
            host_op(s, d[s], cnts[s], 1'b1);
         end
         wait_done(4'b1111, 3000, "rand_done");
         for (int s = 0; s < SLOTS; s++)
            rd_check(s, iter(d[s], cnts[s]), $sformatf("rand_word%0d", s));
         check("rand_issues", WIDTH'(n_issue - n0), WIDTH'(tot));
      end

      // reset while slot 1 waits on the core; its late result is stale
      lat_fix = 8;
      n0 = n_issue;
      host_op(1, rnd_word(), 5, 1'b1);
      wait_issue(n0, 100, "mid_issue");
      @(posedge clk);
      #1;
      rst = 1'b1;
      epoch++;
      for (int s = 0; s < SLOTS; s++) begin
         cur[s]  = '0;
         mcnt[s] = 0;
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      lat_fix = 0;
      n0 = n_issue;
      repeat (12) @(negedge clk);
      check("mid_busy", WIDTH'(busy), '0);
      check("mid_done", WIDTH'(done), '0);
      check("mid_issues", WIDTH'(n_issue - n0), '0);
      for (int s = 0; s < SLOTS; s++) rd_check(s, '0, "mid_word");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
